// File: rtl/instr_inv_queue.sv
// rtl/instr_inv_queue.sv - instruction-coherency invalidation queue feeding icache and branch predictor
// Optional store-line coalescing when INSTR_INV_COALESCE_EN is defined.
module instr_inv_queue #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = 4,
  parameter int LA_W   = 30 - $clog2(LINE_W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inv_valid,
  input  logic [29:0]     inv_addr,
  output logic            icache_inv_valid,
  output logic [LA_W-1:0] icache_inv_addr,
  input  logic            icache_inv_ack,
  output logic            bp_inv_valid,
  output logic [LA_W-1:0] bp_inv_addr,
  input  logic            bp_inv_ack,
  output logic            flush_all_req,
  input  logic            flush_all_ack,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(LINE_W);

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

  state_t          state;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count, count_nxt;
  logic            ic_done, bp_done, ovf_pend;
  logic [LA_W-1:0] mem [DEPTH];

  logic [LA_W-1:0] key;
  logic            ic_fin, bp_fin, pop, drop, push, overflow, ovf_nxt;

  assign key = inv_addr[29:OW];

  assign icache_inv_valid = (state == ISSUE) && !ic_done;
  assign bp_inv_valid     = (state == ISSUE) && !bp_done;
  assign icache_inv_addr  = (state == ISSUE) ? mem[head] : '0;
  assign bp_inv_addr      = (state == ISSUE) ? mem[head] : '0;
  assign flush_all_req    = (state == FLUSH);
  assign empty            = (state == IDLE) && (count == '0) && !ovf_pend;

  // An ack only counts while the matching valid is up.
  assign ic_fin = ic_done || (icache_inv_ack && icache_inv_valid);
  assign bp_fin = bp_done || (bp_inv_ack && bp_inv_valid);
  assign pop    = (state == ISSUE) && (count != '0) && ic_fin && bp_fin;

`ifdef INSTR_INV_COALESCE_EN
  // Match against the youngest entry, unless it is the head leaving this cycle.
  assign drop = inv_valid && (count != '0) && (mem[tail - PW'(1)] == key)
                && !(pop && count == CW'(1));
`else
  assign drop = 1'b0;
`endif

  assign push      = inv_valid && !drop && ((count < CW'(DEPTH)) || pop);
  assign overflow  = inv_valid && !drop && (count == CW'(DEPTH)) && !pop;
  assign ovf_nxt   = ovf_pend || overflow;
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= key;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ic_done  <= 1'b0;
      bp_done  <= 1'b0;
      ovf_pend <= 1'b0;
    end else begin
      head     <= pop  ? head + PW'(1) : head;
      tail     <= push ? tail + PW'(1) : tail;
      count    <= count_nxt;
      ovf_pend <= ovf_nxt;
      ic_done  <= pop ? 1'b0 : ic_fin;
      bp_done  <= pop ? 1'b0 : bp_fin;

      case (state)
        IDLE: begin
          if (ovf_pend) state <= FLUSH;
          else if (push) state <= ISSUE;
        end
        ISSUE: begin
          if (pop) begin
            if (ovf_nxt) state <= FLUSH;
            else if (count_nxt == '0) state <= IDLE;
          end
        end
        FLUSH: begin
          if (flush_all_ack) begin
            if (ovf_nxt) state <= FLUSH;
            else if (count_nxt != '0) state <= ISSUE;
            else state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Entering (or re-entering) FLUSH discards everything queued so far.
      if ((state == IDLE && ovf_pend) || (state == ISSUE && pop && ovf_nxt) ||
          (state == FLUSH && flush_all_ack && ovf_nxt)) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        ovf_pend <= 1'b0;
        ic_done  <= 1'b0;
        bp_done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_inv_queue.sv
// tb/tb_instr_inv_queue.sv - directed self-checking bench for instr_inv_queue
module tb_instr_inv_queue;

  localparam int LA_W = 28;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            inv_valid = 1'b0;
  logic [29:0]     inv_addr = '0;
  logic            icache_inv_valid, bp_inv_valid, flush_all_req, empty;
  logic [LA_W-1:0] icache_inv_addr, bp_inv_addr;
  logic            icache_inv_ack = 1'b0;
  logic            bp_inv_ack = 1'b0;
  logic            flush_all_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  instr_inv_queue #(.DEPTH(4), .LINE_W(4)) dut (
    .clk(clk), .rst(rst),
    .inv_valid(inv_valid), .inv_addr(inv_addr),
    .icache_inv_valid(icache_inv_valid), .icache_inv_addr(icache_inv_addr),
    .icache_inv_ack(icache_inv_ack),
    .bp_inv_valid(bp_inv_valid), .bp_inv_addr(bp_inv_addr), .bp_inv_ack(bp_inv_ack),
    .flush_all_req(flush_all_req), .flush_all_ack(flush_all_ack),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [29:0] a);
    inv_addr = a;
    inv_valid = 1'b1;
    tick();
    inv_valid = 1'b0;
  endtask

  task automatic ack_both();
    icache_inv_ack = 1'b1;
    bp_inv_ack = 1'b1;
    tick();
    icache_inv_ack = 1'b0;
    bp_inv_ack = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [LA_W-1:0] a);
    chk({tag, "_icv"}, 32'(icache_inv_valid), 32'd1);
    chk({tag, "_bpv"}, 32'(bp_inv_valid), 32'd1);
    chk({tag, "_ica"}, 32'(icache_inv_addr), 32'(a));
    chk({tag, "_bpa"}, 32'(bp_inv_addr), 32'(a));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_icv"}, 32'(icache_inv_valid), 32'd0);
    chk({tag, "_bpv"}, 32'(bp_inv_valid), 32'd0);
    chk({tag, "_req"}, 32'(flush_all_req), 32'd0);
  endtask

  initial begin
    int n_exp;
    // Reset state
    tick();
    chk_idle("rst");
    chk("rst_ica", 32'(icache_inv_addr), 32'd0);
    chk("rst_bpa", 32'(bp_inv_addr), 32'd0);
    rst = 1'b0;
    tick();

    // Single store, line 0x41, both acked together
    push(30'h0000_0104);
    chk_head("single", 28'h41);
    chk("single_empty", 32'(empty), 32'd0);
    ack_both();
    chk_idle("single_pop");

    // Split acks; second store queued behind
    push(30'h200);
    chk_head("split0", 28'h80);
    inv_addr = 30'h300;
    inv_valid = 1'b1;
    icache_inv_ack = 1'b1;
    tick();
    inv_valid = 1'b0;
    icache_inv_ack = 1'b0;
    chk("split_icv", 32'(icache_inv_valid), 32'd0);
    chk("split_bpv", 32'(bp_inv_valid), 32'd1);
    chk("split_bpa", 32'(bp_inv_addr), 32'h80);
    icache_inv_ack = 1'b1;  // ack without valid is ignored
    tick();
    icache_inv_ack = 1'b0;
    chk("split_hold_icv", 32'(icache_inv_valid), 32'd0);
    chk("split_hold_bpv", 32'(bp_inv_valid), 32'd1);
    bp_inv_ack = 1'b1;
    tick();
    bp_inv_ack = 1'b0;
    chk_head("split1", 28'hC0);
    ack_both();
    chk_idle("split_end");

    // Full queue with simultaneous push and pop
    for (int k = 1; k <= 4; k++) push(30'(k << 2));
    chk_head("full", 28'h1);
    inv_addr = 30'(5 << 2);
    inv_valid = 1'b1;
    icache_inv_ack = 1'b1;
    bp_inv_ack = 1'b1;
    tick();
    inv_valid = 1'b0;
    icache_inv_ack = 1'b0;
    bp_inv_ack = 1'b0;
    chk("fullpp_req", 32'(flush_all_req), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      chk_head($sformatf("fullpp%0d", k), 28'(k));
      ack_both();
    end
    chk_idle("fullpp_end");

    // Overflow degrades into a flush-all
    for (int k = 1; k <= 5; k++) push(30'(k << 2));
    chk_head("ovf", 28'h1);
    chk("ovf_req_before", 32'(flush_all_req), 32'd0);
    ack_both();
    chk("ovf_req", 32'(flush_all_req), 32'd1);
    chk("ovf_icv", 32'(icache_inv_valid), 32'd0);
    chk("ovf_empty", 32'(empty), 32'd0);
    tick();
    chk("ovf_req_hold", 32'(flush_all_req), 32'd1);
    flush_all_ack = 1'b1;
    tick();
    flush_all_ack = 1'b0;
    chk_idle("ovf_done");
    flush_all_ack = 1'b1;  // stray ack in IDLE
    tick();
    flush_all_ack = 1'b0;
    chk_idle("stray_fack");

    // Three stores to one line
    push(30'h40);
    push(30'h41);
    push(30'h43);
`ifdef INSTR_INV_COALESCE_EN
    n_exp = 1;
`else
    n_exp = 3;
`endif
    for (int k = 0; k < n_exp; k++) begin
      chk_head($sformatf("coal%0d", k), 28'h10);
      ack_both();
    end
    chk_idle("coal_end");

    // Asynchronous reset in the middle of issuing
    push(30'h100);
    push(30'h200);
    push(30'h300);
    chk_head("arst_pre", 28'h40);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("arst");
    tick();
    rst = 1'b0;
    tick();
    chk_idle("arst_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
